mux_arb_reg: RTL and testbench

Parametrised N:1 datapath selector with a registered output stage and valid/ready handshaking. In direct mode it follows the control FSM's select; in round-robin mode it arbitrates fairly among requesting sources. It sits between multiple result or operand producers and a single consumer in the multicycle datapath. Out-of-range selects have defined behaviour: no transfer and an error flag, never an X output.

---
 rtl/mux_pkg.sv | 11 +
 rtl/rr_pick.sv | 42 ++++
 rtl/mux_arb_reg.sv | 133 +++++++++++++
 tb/tb_mux_arb_reg.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants for the N:1 selector with registered output stage.
package mux_pkg;

    // Operating modes sampled on the mode input every cycle.
    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Largest channel count the selector is intended to be built with.
    localparam int N_MAX = 32;

endpackage : mux_pkg

// File: rtl/rr_pick.sv
// Round-robin picker: finds the first asserted request at or above ptr,
// wrapping from N-1 back to 0. Purely combinational.
module rr_pick
    import mux_pkg::*;
#(
    parameter int N    = 8,
    parameter int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic            found,
    output logic [SELW-1:0] index
);

    // Pad requests to the full index range so any SELW-bit index is in bounds.
    localparam int NPAD = 1 << SELW;

    logic [NPAD-1:0] req_pad;
    logic [SELW:0]   cand;

    assign req_pad = NPAD'(req);

    // Scan N positions starting at ptr; the first hit (lowest offset) wins.
    always_comb begin
        // NOTE: every combinational output gets a default before the loop so
        // no path leaves it unassigned, which would otherwise infer a latch.
        found = 1'b0;
        index = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, ptr} + (SELW + 1)'(k);
            if (cand >= (SELW + 1)'(N)) begin
                cand = cand - (SELW + 1)'(N);
            end
            if (!found && req_pad[cand[SELW-1:0]]) begin
                found = 1'b1;
                index = cand[SELW-1:0];
            end
        end
    end

endmodule : rr_pick

// File: rtl/mux_arb_reg.sv
// N:1 datapath selector with a single registered output stage and
// valid/ready handshaking. Direct mode follows sel; round-robin mode
// arbitrates among requesting channels starting from rr_ptr.
module mux_arb_reg
    import mux_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int N     = 8,
    localparam int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sel_err
);

    localparam int NPAD = 1 << SELW;

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_sel_q, out_sel_d;
    logic             out_valid_q, out_valid_d;
    logic             sel_err_q, sel_err_d;
    logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

    logic             space;
    logic             sel_in_range;
    logic             sel_oob;
    logic [NPAD-1:0]  valid_pad;
    logic             rr_found;
    logic [SELW-1:0]  rr_index;
    logic             grant_valid;
    logic [SELW-1:0]  grant_idx;
    logic             accept;
    logic [WIDTH-1:0] grant_data;

    // The output register can take a word if it is empty or being drained.
    assign space = !out_valid_q || out_ready;

    // Range check one bit wider than sel so sel >= N is caught for any N.
    assign sel_in_range = ({1'b0, sel} < (SELW + 1)'(N));
    assign sel_oob      = (mode == MODE_DIRECT) && !sel_in_range;
    assign valid_pad    = NPAD'(in_valid);

    rr_pick #(
        .N    (N),
        .SELW (SELW)
    ) u_rr_pick (
        .req   (in_valid),
        .ptr   (rr_ptr_q),
        .found (rr_found),
        .index (rr_index)
    );

    // Grant source: round-robin picker or the direct select when in range.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (mode == MODE_RR) begin
            grant_valid = rr_found;
            grant_idx   = rr_index;
        end else begin
            grant_valid = sel_in_range && valid_pad[sel];
            grant_idx   = sel;
        end
    end

    // Held in reset, nothing is accepted so in_ready stays all-zero.
    assign accept = grant_valid && space && !reset;

    // One-hot accept decode and data mux; the loop keeps indices in range.
    always_comb begin
        in_ready   = '0;
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == SELW'(i)) begin
                in_ready[i] = accept;
                grant_data  = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next state for the output register, round-robin pointer and error flag.
    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        sel_err_d   = sel_oob;
        if (accept) begin
            out_data_d  = grant_data;
            out_sel_d   = grant_idx;
            out_valid_d = 1'b1;
            if (mode == MODE_RR) begin
                rr_ptr_d = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples its pre-edge inputs regardless of statement order.
        if (reset) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;
    assign sel_err   = sel_err_q;

endmodule : mux_arb_reg

// File: tb/tb_mux_arb_reg.sv
// Bench for mux_arb_reg: one N=8 and one N=5 instance driven side by side,
// checked every cycle against a behavioural model, plus directed scenarios
// with literal expectations.
module tb_mux_arb_reg;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    // Unit 0: N=8
    logic [8*32-1:0] in_data8;
    logic [7:0]      in_valid8, in_ready8;
    logic            mode8;
    logic [2:0]      sel8;
    logic [31:0]     out_data8;
    logic [2:0]      out_sel8;
    logic            out_valid8, out_ready8, sel_err8;

    // Unit 1: N=5
    logic [5*32-1:0] in_data5;
    logic [4:0]      in_valid5, in_ready5;
    logic            mode5;
    logic [2:0]      sel5;
    logic [31:0]     out_data5;
    logic [2:0]      out_sel5;
    logic            out_valid5, out_ready5, sel_err5;

    mux_arb_reg #(.WIDTH(32), .N(8)) u_dut8 (
        .clk(clk), .reset(reset), .in_data(in_data8), .in_valid(in_valid8),
        .in_ready(in_ready8), .mode(mode8), .sel(sel8), .out_data(out_data8),
        .out_sel(out_sel8), .out_valid(out_valid8), .out_ready(out_ready8),
        .sel_err(sel_err8)
    );

    mux_arb_reg #(.WIDTH(32), .N(5)) u_dut5 (
        .clk(clk), .reset(reset), .in_data(in_data5), .in_valid(in_valid5),
        .in_ready(in_ready5), .mode(mode5), .sel(sel5), .out_data(out_data5),
        .out_sel(out_sel5), .out_valid(out_valid5), .out_ready(out_ready5),
        .sel_err(sel_err5)
    );

    // Stimulus per unit
    int        nch [2] = '{8, 5};
    bit [31:0] din [2][8];
    bit [7:0]  vin [2];
    bit        mode_v [2];
    bit [2:0]  sel_v [2];
    bit        ordy [2];

    // Behavioural model state per unit
    bit [31:0] m_data [2];
    int        m_sel [2];
    bit        m_valid [2];
    bit        m_err [2];
    int        m_ptr [2];

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic apply(input bit rst);
        reset = rst;
        for (int i = 0; i < 8; i++) in_data8[i*32 +: 32] = din[0][i];
        for (int i = 0; i < 5; i++) in_data5[i*32 +: 32] = din[1][i];
        in_valid8  = vin[0];
        in_valid5  = vin[1][4:0];
        mode8      = mode_v[0];
        mode5      = mode_v[1];
        sel8       = sel_v[0];
        sel5       = sel_v[1];
        out_ready8 = ordy[0];
        out_ready5 = ordy[1];
    endtask

    // Which channel the rules grant this cycle, or -1 for none.
    function automatic int model_grant(input int u);
        int j;
        if (mode_v[u] == 1'b0) begin
            if (int'(sel_v[u]) >= nch[u]) return -1;
            return vin[u][sel_v[u]] ? int'(sel_v[u]) : -1;
        end
        for (int k = 0; k < nch[u]; k++) begin
            j = (m_ptr[u] + k) % nch[u];
            if (vin[u][j]) return j;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        for (int u = 0; u < 2; u++) begin
            m_data[u]  = '0;
            m_sel[u]   = 0;
            m_valid[u] = 1'b0;
            m_err[u]   = 1'b0;
            m_ptr[u]   = 0;
        end
    endfunction

    // One clock: drive, compare at the falling edge, advance the model.
    task automatic step(input bit rst);
        int          g;
        bit          sp;
        logic [63:0] exp_rdy, a_rdy, a_data, a_sel;
        logic        a_valid, a_err;
        apply(rst);
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            g  = model_grant(u);
            sp = !m_valid[u] || ordy[u];
            exp_rdy = (!rst && g >= 0 && sp) ? (64'd1 << g) : 64'd0;
            if (u == 0) begin
                a_rdy = 64'(in_ready8); a_data = 64'(out_data8); a_sel = 64'(out_sel8);
                a_valid = out_valid8; a_err = sel_err8;
            end else begin
                a_rdy = 64'(in_ready5); a_data = 64'(out_data5); a_sel = 64'(out_sel5);
                a_valid = out_valid5; a_err = sel_err5;
            end
            check($sformatf("u%0d in_ready", u), a_rdy, exp_rdy);
            check($sformatf("u%0d out_valid", u), 64'(a_valid), 64'(m_valid[u]));
            check($sformatf("u%0d out_data", u), a_data, 64'(m_data[u]));
            check($sformatf("u%0d out_sel", u), a_sel, 64'(m_sel[u]));
            check($sformatf("u%0d sel_err", u), 64'(a_err), 64'(m_err[u]));
            if (!rst) begin
                m_err[u] = (mode_v[u] == 1'b0) && (int'(sel_v[u]) >= nch[u]);
                if (g >= 0 && sp) begin
                    m_data[u]  = din[u][g];
                    m_sel[u]   = g;
                    m_valid[u] = 1'b1;
                    if (mode_v[u]) m_ptr[u] = (g + 1) % nch[u];
                end else if (ordy[u]) begin
                    m_valid[u] = 1'b0;
                end
            end
        end
        if (rst) model_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 8; i++) din[u][i] = '0;
            vin[u] = '0; mode_v[u] = 1'b0; sel_v[u] = '0; ordy[u] = 1'b1;
        end
        apply(1'b1);
        @(posedge clk);
        #1;
        model_reset();
        step(1'b1);
        check("lit reset out_valid", 64'(out_valid8), 64'd0);

        // Direct select of channel 3
        sel_v[0] = 3'd3; vin[0] = 8'h08; din[0][3] = 32'hDEAD_BEEF; ordy[0] = 1'b1;
        step(1'b0);
        check("lit direct out_data", 64'(out_data8), 64'hDEAD_BEEF);
        check("lit direct out_sel", 64'(out_sel8), 64'd3);
        check("lit direct out_valid", 64'(out_valid8), 64'd1);
        check("lit direct in_ready", 64'(in_ready8), 64'h08);

        // Backpressure for three cycles, then release with a new word
        din[0][3] = 32'h1234_5678; ordy[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1'b0);
            check("lit bp in_ready", 64'(in_ready8), 64'd0);
            check("lit bp out_data", 64'(out_data8), 64'hDEAD_BEEF);
        end
        ordy[0] = 1'b1;
        step(1'b0);
        check("lit bp release data", 64'(out_data8), 64'h1234_5678);

        // Round-robin sweep from reset, then alternating 0/7
        step(1'b1);
        mode_v[0] = 1'b1; vin[0] = 8'hFF;
        for (int k = 0; k < 8; k++) begin
            step(1'b0);
            check($sformatf("lit rr sweep %0d", k), 64'(out_sel8), 64'(k));
        end
        vin[0] = 8'h81;
        for (int k = 0; k < 4; k++) begin
            step(1'b0);
            check($sformatf("lit rr alt %0d", k), 64'(out_sel8), (k % 2 == 0) ? 64'd0 : 64'd7);
        end
        vin[0] = 8'h00;

        // N=5 out-of-range select, then pointer wrap 4 -> 0
        mode_v[1] = 1'b0; sel_v[1] = 3'd6; vin[1] = 8'h1F; ordy[1] = 1'b1;
        step(1'b0);
        check("lit n5 sel_err set", 64'(sel_err5), 64'd1);
        check("lit n5 no output", 64'(out_valid5), 64'd0);
        check("lit n5 in_ready", 64'(in_ready5), 64'd0);
        sel_v[1] = 3'd1; vin[1] = 8'h00;
        step(1'b0);
        check("lit n5 sel_err clear", 64'(sel_err5), 64'd0);
        mode_v[1] = 1'b1; vin[1] = 8'h10;
        step(1'b0);
        check("lit n5 rr grant 4", 64'(out_sel5), 64'd4);
        vin[1] = 8'h1F;
        step(1'b0);
        check("lit n5 rr wrap 0", 64'(out_sel5), 64'd0);
        vin[1] = 8'h00;

        // Reset while holding a word under backpressure
        mode_v[0] = 1'b0; sel_v[0] = 3'd3; vin[0] = 8'h08; din[0][3] = 32'hA5A5_A5A5;
        ordy[0] = 1'b1;
        step(1'b0);
        ordy[0] = 1'b0;
        step(1'b0);
        check("lit held valid", 64'(out_valid8), 64'd1);
        step(1'b1);
        check("lit rst out_valid", 64'(out_valid8), 64'd0);
        check("lit rst out_data", 64'(out_data8), 64'd0);
        mode_v[0] = 1'b1; vin[0] = 8'h0C; ordy[0] = 1'b1;
        step(1'b0);
        check("lit rst first rr", 64'(out_sel8), 64'd2);

        // Randomised traffic on both units with occasional reset
        for (int c = 0; c < 1500; c++) begin
            for (int u = 0; u < 2; u++) begin
                for (int i = 0; i < 8; i++) din[u][i] = $urandom;
                vin[u]    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
                if (u == 1) vin[u] = vin[u] & 8'h1F;
                mode_v[u] = 1'($urandom);
                sel_v[u]  = 3'($urandom);
                ordy[u]   = ($urandom_range(0, 3) != 0);
            end
            step($urandom_range(0, 63) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_mux_arb_reg
